// File: rtl/alu_pkg.sv
// Shared op-code and FSM state definitions for the multicycle ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier: WIDTH partial-product steps, the
// first applied on the start edge, so done rises WIDTH-1 cycles after start.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic                 running;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;

  assign done    = running && (cnt == '0);
  assign product = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= CW'(WIDTH - 1);
    end else if (done) begin
      running <= 1'b0;
    end else if (running) begin
      cnt     <= cnt - CW'(1);
    end
  end

  // Step count is independent of operand values, so latency stays fixed.
  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
    end else if (running && (cnt != '0)) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus a sequential MUL,
// with a valid/ready handshake on both sides and registered result/flags.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       nvz,
  output logic             busy
);

  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  alu_state_t state, state_nxt;

  logic                  xfer;
  logic                  mul_start;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_prod;
  logic [WIDTH-1:0]      res;
  logic                  ovf;
  logic signed [WIDTH-1:0] a_s;
  logic [SHW-1:0]        shamt;

  function automatic logic [2:0] make_flags(input logic [WIDTH-1:0] r, input logic v);
    return {r[WIDTH-1], v, (r == '0)};
  endfunction

  assign xfer      = (state == ST_IDLE) && in_valid;
  assign mul_start = xfer && (ALUop == OP_MUL);
  assign a_s       = Ain;
  assign shamt     = Bin[SHW-1:0];

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_BUSY);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (Ain),
    .b       (Bin),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (ALUop)
      OP_ADD: begin
        res = Ain + Bin;
        ovf = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        res = Ain - Bin;
        ovf = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND:  res = Ain & Bin;
      OP_NOT:  res = ~Bin;
      OP_SHL:  res = Ain << shamt;
      OP_SHR:  res = Ain >> shamt;
      OP_SRA:  res = a_s >>> shamt;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = (ALUop == OP_MUL) ? ST_BUSY : ST_DONE;
      ST_BUSY: if (mul_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers only load on a single-cycle transfer or MUL completion,
  // so they hold steady throughout DONE regardless of input activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      out   <= '0;
      nvz   <= 3'b001;
    end else begin
      state <= state_nxt;
      if (xfer && (ALUop != OP_MUL)) begin
        out <= res;
        nvz <= make_flags(res, ovf);
      end else if ((state == ST_BUSY) && mul_done) begin
        out <= mul_prod[WIDTH-1:0];
        nvz <= make_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH]);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=16: expected results are queued
// at transfer and compared when out_valid rises.
module tb_multicycle_alu;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  Ain = '0;
  logic [W-1:0]  Bin = '0;
  logic [2:0]    ALUop = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out;
  logic [2:0]    nvz;
  logic          busy;

  int vectors = 0;
  int errors  = 0;
  logic [18:0] exp_q[$];

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Ain(Ain), .Bin(Bin), .ALUop(ALUop), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .nvz(nvz), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    logic [31:0] p;
    r = 16'h0;
    v = 1'b0;
    p = 32'h0;
    case (op)
      3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: r = a << b[3:0];
      3'd5: r = a >> b[3:0];
      3'd6: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) r = {r[15], r[15:1]};
      end
      default: begin
        p = {16'h0, a} * {16'h0, b};
        r = p[15:0];
        v = (p[31:16] != 16'h0);
      end
    endcase
    return {r, r[15], v, (r == 16'h0)};
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [18:0] exp;
    logic [15:0] so;
    logic [2:0]  sn;
    int n, lat, bcnt, exp_lat, exp_busy;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_op: in_ready=%b required 1", in_ready);
    end
    ALUop = op; Ain = a; Bin = b; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    lat = 1; bcnt = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bcnt++;
      in_valid = 1'($urandom_range(0, 1)); Ain = 16'($urandom); Bin = 16'($urandom); ALUop = 3'($urandom);
      @(posedge clk); #1; lat++;
    end
    exp_lat  = (op == 3'b111) ? 17 : 1;
    exp_busy = (op == 3'b111) ? 16 : 0;
    vectors++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency op=%0d: got %0d cycles required %0d", op, lat, exp_lat);
    end
    vectors++;
    if (bcnt != exp_busy) begin
      errors++;
      $display("FAIL busy_cycles op=%0d: got %0d required %0d", op, bcnt, exp_busy);
    end
    so = out; sn = nvz;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; Ain = 16'($urandom); Bin = 16'($urandom); ALUop = 3'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (out !== so || nvz !== sn || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d: out=%h nvz=%b rdy=%b vld=%b required out=%h nvz=%b rdy=0 vld=1",
                 i, out, nvz, in_ready, out_valid, so, sn);
      end
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
    vectors++;
    if ({out, nvz} !== exp) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: out=%h nvz=%b required out=%h nvz=%b",
               op, a, b, out, nvz, exp[18:3], exp[2:0]);
    end
    out_ready = 1'b1; in_valid = 1'b1; ALUop = 3'b000;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL return_idle: in_ready=%b out_valid=%b required 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 16'h0 || nvz !== 3'b001) begin
      errors++;
      $display("FAIL %s: rdy=%b vld=%b busy=%b out=%h nvz=%b required 1 0 0 0000 001",
               tag, in_ready, out_valid, busy, out, nvz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    check_reset_values("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("after_release");
  endtask

  task automatic test_add_sub_and();
    run_op(3'd0, 16'h7FFF, 16'h0001, 0);
    run_op(3'd1, 16'h0005, 16'h0005, 0);
    run_op(3'd2, 16'hF0F0, 16'h0FF0, 0);
    run_op(3'd1, 16'h8000, 16'h0001, 0);
    run_op(3'd3, 16'h1234, 16'h00FF, 0);
  endtask

  task automatic test_mul();
    run_op(3'd7, 16'h0100, 16'h0100, 0);
    run_op(3'd7, 16'h0003, 16'h0005, 0);
    run_op(3'd7, 16'hBEEF, 16'h0000, 0);
    run_op(3'd7, 16'hFFFF, 16'hFFFF, 0);
  endtask

  task automatic test_shifts();
    run_op(3'd6, 16'h8000, 16'h0004, 0);
    run_op(3'd4, 16'hA5C3, 16'h0000, 0);
    run_op(3'd4, 16'h0001, 16'h000F, 0);
    run_op(3'd5, 16'h8000, 16'h00F3, 0);
    run_op(3'd6, 16'h7000, 16'h0002, 0);
  endtask

  task automatic test_backpressure();
    run_op(3'd0, 16'h1234, 16'h4321, 5);
    run_op(3'd7, 16'h0123, 16'h0045, 5);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    while (in_ready !== 1'b1) begin @(posedge clk); #1; end
    ALUop = 3'd7; Ain = 16'h0100; Bin = 16'h0100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    check_reset_values("reset_mid_mul");
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted_mul: out_valid seen %0d cycles required 0", seen);
    end
    check_reset_values("post_abort_idle");
    run_op(3'd0, 16'h0010, 16'h0020, 0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++)
      run_op(3'($urandom), 16'($urandom), 16'($urandom), 0);
  endtask

  initial begin
    test_reset();
    test_add_sub_and();
    test_mul();
    test_shifts();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
